mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state, the RAM and the output register.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 en  in  1  advance enable from the hazard unit; 0 freezes the whole block.
REQ-005 flush  in  1  squash the incoming instruction (sampled in IDLE only).
REQ-006 pc_in, instr_in, alu_res1_in, alu_res2_in, dmem_in_in  in  32 each  fields from EXE/MEM; alu_res1_in is the ALU result, dmem_in_in is the store data.
REQ-007 dmem_addr_in  in  10  byte address into data RAM.
REQ-008 mem_to_reg_in, mem_write_in, reg_write_in, jump_in, pause_in, half_in  in  1 each  control flags from EXE/MEM.
REQ-009 rd_addr_in  in  5  destination register.
REQ-010 pc_out, instr_out, alu_res2_out  out  32 each  registered pass-through to WB.
REQ-011 wb_data_out  out  32  registered write-back value.
REQ-012 reg_write_out, jump_out, pause_out  out  1 each  registered to WB.
REQ-013 rd_addr_out  out  5  registered to WB.
REQ-014 stall_req  out  1  combinational; holds EXE/MEM and earlier stages.

Function
REQ-015 The block SHALL contain a 256x32 data RAM with synchronous read and synchronous write.
- Word index = dmem_addr_in[9:2].
- Half select = dmem_addr_in[1] (1 = bits 31:16).
- dmem_addr_in[0] is ignored.
REQ-016 The FSM SHALL have three states: IDLE, LOAD and MERGE. In IDLE, an operation is a load when mem_to_reg_in=1, and a half store when mem_write_in=1 and half_in=1.
REQ-017 IDLE, word store (mem_write_in=1, half_in=0): the RAM word SHALL be written with dmem_in_in at the edge; stall_req=0; single cycle.
REQ-018 IDLE, load: the RAM read SHALL be issued, stall_req=1, the output register SHALL load a bubble, and the next state is LOAD.
REQ-019 LOAD: stall_req=0, and the output register SHALL capture the instruction. wb_data_out is the read word, or for half_in=1 the selected halfword sign-extended to 32 bits. The next state is IDLE.
REQ-020 IDLE, half store: the RAM read SHALL be issued, stall_req=1, the output register SHALL load a bubble, and the next state is MERGE.
REQ-021 MERGE: the word SHALL be written back with only the selected halfword replaced by dmem_in_in[15:0]. stall_req=0, the output register captures the instruction, and the next state is IDLE.
REQ-022 Any other instruction SHALL complete in IDLE in one cycle with wb_data_out = alu_res1_in.
REQ-023 A bubble SHALL be all output-register fields = 0, including reg_write_out, jump_out and pause_out.
REQ-024 The upstream stages SHALL hold all inputs stable while stall_req=1.
REQ-025 When en=0:
- FSM state, outputs and RAM SHALL be unchanged.
- No RAM write occurs.
- stall_req SHALL still reflect the IDLE decode.
REQ-026 flush=1 in IDLE SHALL suppress any RAM write, load a bubble and keep the FSM in IDLE. flush SHALL be ignored in LOAD and MERGE, where the in-flight operation completes.
REQ-027 A RAM write at an edge SHALL be visible to a read issued at any later edge: back-to-back store then load to the same word returns the new data.
REQ-028 alu_res2_out, pc_out, instr_out, rd_addr_out, jump_out and pause_out SHALL be the captured inputs of the completing instruction.

Reset
REQ-029 rst=0 SHALL immediately force the FSM to IDLE and all registered outputs to 0. stall_req then follows the IDLE decode of the current inputs.
REQ-030 Reset in LOAD or MERGE SHALL abort the operation with no RAM write. RAM contents are not reset.

Verification
REQ-031 Word store 0xDEADBEEF at addr 0x010, then load at 0x010 -> stall_req=1 for one cycle, then wb_data_out=0xDEADBEEF with reg_write_out as supplied.
REQ-032 Half store 0x1234 at addr 0x012 over word 0xAAAABBBB -> one stall cycle; the word becomes 0x1234BBBB; a later half load at 0x012 returns 0x00001234.
REQ-033 Half load at 0x010 of word 0x0000F00D -> wb_data_out=0xFFFFF00D (sign-extended).
REQ-034 ALU instruction with alu_res1_in=0x55, rd=7 -> next edge wb_data_out=0x55, rd_addr_out=7, stall_req=0 throughout.
REQ-035 Store with flush=1 -> RAM unchanged and a bubble output. Load then flush=1 asserted in LOAD -> the load still completes.
REQ-036 rst low during MERGE -> outputs 0, state IDLE, target word unchanged. en=0 held two cycles in LOAD -> outputs frozen, completes after en=1.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : pipeline MEM stage with a 256x32 data RAM, word/half load/store
// Revision  : 1.0 - initial release
// ============================================================================
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] alu_res1_in,
  input  logic [31:0] alu_res2_in,
  input  logic [31:0] dmem_in_in,
  input  logic [9:0]  dmem_addr_in,
  input  logic        mem_to_reg_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic        jump_in,
  input  logic        pause_in,
  input  logic        half_in,
  input  logic [4:0]  rd_addr_in,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [31:0] alu_res2_out,
  output logic [31:0] wb_data_out,
  output logic        reg_write_out,
  output logic        jump_out,
  output logic        pause_out,
  output logic [4:0]  rd_addr_out,
  output logic        stall_req
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MERGE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] ram [0:255];
  logic [31:0] rd_word;

  logic [7:0]  ram_idx;
  logic        half_sel;
  logic        addr_unused;
  logic        is_load;
  logic        is_hstore;
  logic        is_wstore;
  logic        in_idle;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_wdata;
  logic [31:0] merged;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  assign ram_idx     = dmem_addr_in[9:2];
  assign half_sel    = dmem_addr_in[1];
  assign addr_unused = dmem_addr_in[0];

  // A load takes priority if both load and store flags are ever set together.
  assign is_load   = mem_to_reg_in;
  assign is_hstore = !mem_to_reg_in && mem_write_in && half_in;
  assign is_wstore = !mem_to_reg_in && mem_write_in && !half_in;
  assign in_idle   = (state == IDLE);

  assign stall_req = in_idle && !flush && (is_load || is_hstore);

  assign merged    = half_sel ? {dmem_in_in[15:0], rd_word[15:0]}
                              : {rd_word[31:16], dmem_in_in[15:0]};
  assign sel_half  = half_sel ? rd_word[31:16] : rd_word[15:0];
  assign load_data = half_in ? {{16{sel_half[15]}}, sel_half} : rd_word;

  // Writes are gated by rst so an edge during reset cannot commit a store.
  assign ram_we    = en && rst && ((in_idle && !flush && is_wstore) || (state == MERGE));
  assign ram_re    = en && stall_req;
  assign ram_wdata = (state == MERGE) ? merged : dmem_in_in;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= ram_wdata;
    end
    if (ram_re) begin
      rd_word <= ram[ram_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pc_out        <= '0;
      instr_out     <= '0;
      alu_res2_out  <= '0;
      wb_data_out   <= '0;
      reg_write_out <= 1'b0;
      jump_out      <= 1'b0;
      pause_out     <= 1'b0;
      rd_addr_out   <= '0;
    end else if (en) begin
      if (in_idle && (flush || stall_req)) begin
        pc_out        <= '0;
        instr_out     <= '0;
        alu_res2_out  <= '0;
        wb_data_out   <= '0;
        reg_write_out <= 1'b0;
        jump_out      <= 1'b0;
        pause_out     <= 1'b0;
        rd_addr_out   <= '0;
      end else begin
        pc_out        <= pc_in;
        instr_out     <= instr_in;
        alu_res2_out  <= alu_res2_in;
        wb_data_out   <= (state == LOAD) ? load_data : alu_res1_in;
        reg_write_out <= reg_write_in;
        jump_out      <= jump_in;
        pause_out     <= pause_in;
        rd_addr_out   <= rd_addr_in;
      end
      case (state)
        IDLE: begin
          if (stall_req) begin
            state <= is_load ? LOAD : MERGE;
          end
        end
        LOAD:    state <= IDLE;
        MERGE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
